// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction generator/receiver pair.
// Holds the FSM state encoding (4 bits wide, same style as the generator),
// the byte size, ACK/NACK line levels and the address-match helper.
package i2c_pkg;

    localparam int   I2C_BYTE_BITS = 8;
    localparam logic I2C_ACK       = 1'b0;
    localparam logic I2C_NACK      = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_RX       = 4'd3,
        ST_RX_ACK   = 4'd4,
        ST_TX       = 4'd5,
        ST_TX_ACK   = 4'd6,
        ST_IGNORE   = 4'd7
    } i2c_state_e;

    // The general call address (0x00) is never answered.
    function automatic logic addr_match(input logic [6:0] rx_addr, input logic [6:0] own_addr);
        return (rx_addr == own_addr) && (rx_addr != 7'd0);
    endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: samples SCL/SDA into clk_sys domain and flags bus events.
// Ports:
//   clk, rst          - system clock, async active-high reset
//   scl_i, sda_i      - raw bus lines
//   sda_o             - registered SDA sample
//   scl_rise_o/fall_o - SCL edge strobes (one clk each)
//   start_o, stop_o   - START/STOP conditions (need SCL high in both samples)
module i2c_bus_monitor (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic scl_q, scl_qq, sda_q, sda_qq;

    // Sampling flops reset to an idle (high) bus so reset itself is no event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q  <= 1'b1;
            scl_qq <= 1'b1;
            sda_q  <= 1'b1;
            sda_qq <= 1'b1;
        end else begin
            scl_q  <= scl_i;
            scl_qq <= scl_q;
            sda_q  <= sda_i;
            sda_qq <= sda_q;
        end
    end

    assign sda_o      = sda_q;
    assign scl_rise_o = scl_q & ~scl_qq;
    assign scl_fall_o = ~scl_q & scl_qq;
    assign start_o    = scl_q & scl_qq & sda_qq & ~sda_q;
    assign stop_o     = scl_q & scl_qq & ~sda_qq & sda_q;

endmodule

// File: rtl/i2c_transaction_receiver.sv
// I2C target: matches a 7-bit address and performs one DATA_BYTES transfer.
// Ports:
//   clk, rst     - system clock (SCL <= clk/4), async active-high reset
//   scl, sda_in  - bus clock and resolved SDA
//   i2c_addr     - own address
//   rd_data_in   - word returned on reads, latched at address ACK
//   sda_out/oe   - SDA drive value / enable
//   wr_data      - last complete written word, wr_valid pulses on update
//   busy         - START seen, STOP not yet seen
module i2c_transaction_receiver
    import i2c_pkg::*;
#(
    parameter int DATA_BYTES = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scl,
    input  logic                        sda_in,
    input  logic [6:0]                  i2c_addr,
    input  logic [8*DATA_BYTES-1:0]     rd_data_in,
    output logic                        sda_out,
    output logic                        sda_oe,
    output logic [8*DATA_BYTES-1:0]     wr_data,
    output logic                        wr_valid,
    output logic                        busy
);

    localparam int W   = I2C_BYTE_BITS * DATA_BYTES;
    localparam int BCW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_bus_monitor u_mon (
        .clk        (clk),
        .rst        (rst),
        .scl_i      (scl),
        .sda_i      (sda_in),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (start),
        .stop_o     (stop)
    );

    i2c_state_e     state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic           byte_done_q, byte_done_d;
    logic           ack_q, ack_d;
    logic [W-1:0]   shift_q, shift_d;
    logic [W-1:0]   tx_q, tx_d;
    logic [W-1:0]   wr_data_q, wr_data_d;
    logic           sda_out_q, sda_out_d, sda_oe_q, sda_oe_d;
    logic           wr_valid_q, wr_valid_d, busy_q, busy_d;

    logic addr_ok;
    assign addr_ok = addr_match(shift_q[7:1], i2c_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_ADDR;
        end else if (stop) begin
            state_d = ST_IDLE;
        end else if (scl_fall) begin
            case (state_q)
                ST_ADDR:     if (byte_done_q) state_d = addr_ok ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK: state_d = shift_q[0] ? ST_TX : ST_RX;
                ST_RX:       if (byte_done_q) state_d = ST_RX_ACK;
                ST_RX_ACK:   state_d = (byte_cnt_q != '0) ? ST_RX : ST_IGNORE;
                ST_TX:       if (bit_cnt_q == 3'd0) state_d = ST_TX_ACK;
                ST_TX_ACK:   state_d = (ack_q == I2C_ACK && byte_cnt_q != '0) ? ST_TX : ST_IGNORE;
                default:     state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        byte_done_d = byte_done_q;
        ack_d       = ack_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        wr_data_d   = wr_data_q;
        sda_out_d   = sda_out_q;
        sda_oe_d    = sda_oe_q;
        wr_valid_d  = 1'b0;
        busy_d      = busy_q;
        if (start) begin
            bit_cnt_d   = 3'd7;
            byte_done_d = 1'b0;
            sda_out_d   = 1'b1;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b1;
        end else if (stop) begin
            byte_done_d = 1'b0;
            sda_out_d   = 1'b1;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_RX: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[W-2:0], sda_s};
                        if (bit_cnt_q == 3'd0) byte_done_d = 1'b1;
                        else                   bit_cnt_d   = bit_cnt_q - 3'd1;
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        bit_cnt_d   = 3'd7;
                        if (state_q == ST_RX || addr_ok) begin
                            sda_out_d = I2C_ACK;
                            sda_oe_d  = 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        byte_cnt_d = BCW'(DATA_BYTES - 1);
                        bit_cnt_d  = 3'd7;
                        if (shift_q[0]) begin
                            tx_d      = rd_data_in;
                            sda_out_d = rd_data_in[W-1];
                            sda_oe_d  = 1'b1;
                        end else begin
                            sda_out_d = 1'b1;
                            sda_oe_d  = 1'b0;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_out_d = 1'b1;
                        sda_oe_d  = 1'b0;
                        if (byte_cnt_q != '0) begin
                            byte_cnt_d = byte_cnt_q - BCW'(1);
                        end else begin
                            wr_data_d  = shift_q;
                            wr_valid_d = 1'b1;
                        end
                    end
                end
                ST_TX: begin
                    // tx_q shifts on every fall incl. the release, so the next
                    // byte's MSB sits at the top once TX_ACK is reached.
                    if (scl_fall) begin
                        tx_d = {tx_q[W-2:0], 1'b0};
                        if (bit_cnt_q != 3'd0) begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                            sda_out_d = tx_q[W-2];
                        end else begin
                            sda_out_d = 1'b1;
                            sda_oe_d  = 1'b0;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) ack_d = sda_s;
                    if (scl_fall && ack_q == I2C_ACK && byte_cnt_q != '0) begin
                        byte_cnt_d = byte_cnt_q - BCW'(1);
                        bit_cnt_d  = 3'd7;
                        sda_out_d  = tx_q[W-1];
                        sda_oe_d   = 1'b1;
                    end
                end
                default: begin
                    sda_out_d = 1'b1;
                    sda_oe_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            byte_done_q <= 1'b0;
            ack_q       <= 1'b0;
            shift_q     <= '0;
            tx_q        <= '0;
            wr_data_q   <= '0;
            sda_out_q   <= 1'b1;
            sda_oe_q    <= 1'b0;
            wr_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            byte_done_q <= byte_done_d;
            ack_q       <= ack_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            wr_data_q   <= wr_data_d;
            sda_out_q   <= sda_out_d;
            sda_oe_q    <= sda_oe_d;
            wr_valid_q  <= wr_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_out  = sda_out_q;
    assign sda_oe   = sda_oe_q;
    assign wr_data  = wr_data_q;
    assign wr_valid = wr_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_transaction_receiver.sv
// Directed bench for i2c_transaction_receiver: a simple bus master drives
// SCL/SDA at clk/8 and the resolved SDA line is modelled as wired-AND.
module tb_i2c_transaction_receiver;
    import i2c_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        scl, m_sda;
    logic [6:0]  i2c_addr;
    logic [15:0] rd_data_in;
    logic        sda_out, sda_oe, wr_valid, busy;
    logic [15:0] wr_data;
    logic        sda_line;

    int n_cmp = 0;
    int n_bad = 0;
    int wv_count;
    logic oe_seen;
    logic samp_oe, samp_out;

    assign sda_line = m_sda & (sda_oe ? sda_out : 1'b1);

    i2c_transaction_receiver #(.DATA_BYTES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl        (scl),
        .sda_in     (sda_line),
        .i2c_addr   (i2c_addr),
        .rd_data_in (rd_data_in),
        .sda_out    (sda_out),
        .sda_oe     (sda_oe),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_valid) wv_count = wv_count + 1;
        if (sda_oe)   oe_seen  = 1'b1;
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic v);
        scl = 1'b0;
        wclk(2);
        m_sda = b;
        wclk(2);
        scl = 1'b1;
        wclk(2);
        v        = sda_line;
        samp_oe  = sda_oe;
        samp_out = sda_out;
        wclk(2);
    endtask

    task automatic bus_start();
        scl = 1'b0;
        wclk(2);
        m_sda = 1'b1;
        wclk(2);
        scl = 1'b1;
        wclk(4);
        m_sda = 1'b0;
        wclk(4);
    endtask

    task automatic bus_stop();
        scl = 1'b0;
        wclk(2);
        m_sda = 1'b0;
        wclk(2);
        scl = 1'b1;
        wclk(4);
        m_sda = 1'b1;
        wclk(4);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a_oe, output logic a_out);
        logic v;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], v);
        clock_bit(1'b1, v);
        a_oe  = samp_oe;
        a_out = samp_out;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, v);
            d[i] = v;
        end
        clock_bit(mack, v);
    endtask

    task automatic test_reset();
        rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
        i2c_addr = 7'h2A; rd_data_in = 16'h0000;
        wv_count = 0; oe_seen = 1'b0;
        wclk(3);
        n_cmp++; if (sda_out !== 1'b1)   begin n_bad++; $display("FAIL reset_sda_out: got %b want 1", sda_out); end
        n_cmp++; if (sda_oe !== 1'b0)    begin n_bad++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        n_cmp++; if (wr_data !== 16'h0)  begin n_bad++; $display("FAIL reset_wr_data: got %h want 0000", wr_data); end
        n_cmp++; if (wr_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        wclk(4);
    endtask

    task automatic test_write(input logic [7:0] b0, input logic [7:0] b1, input string tag);
        logic a_oe, a_out;
        bus_start();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy_rise: got %b want 1", tag, busy); end
        wv_count = 0;
        send_byte(8'h54, a_oe, a_out);
        n_cmp++; if ({a_oe, a_out} !== 2'b10) begin n_bad++; $display("FAIL %s_addr_ack: oe/out got %b%b want 10", tag, a_oe, a_out); end
        send_byte(b0, a_oe, a_out);
        n_cmp++; if ({a_oe, a_out} !== 2'b10) begin n_bad++; $display("FAIL %s_data0_ack: oe/out got %b%b want 10", tag, a_oe, a_out); end
        send_byte(b1, a_oe, a_out);
        n_cmp++; if ({a_oe, a_out} !== 2'b10) begin n_bad++; $display("FAIL %s_data1_ack: oe/out got %b%b want 10", tag, a_oe, a_out); end
        bus_stop();
        n_cmp++; if (wr_data !== {b0, b1}) begin n_bad++; $display("FAIL %s_wr_data: got %h want %h", tag, wr_data, {b0, b1}); end
        n_cmp++; if (wv_count !== 1) begin n_bad++; $display("FAIL %s_wr_valid_cycles: got %0d want 1", tag, wv_count); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_fall: got %b want 0", tag, busy); end
    endtask

    task automatic test_read();
        logic a_oe, a_out;
        logic [7:0] d0, d1;
        rd_data_in = 16'hA5C3;
        bus_start();
        send_byte(8'h55, a_oe, a_out);
        n_cmp++; if ({a_oe, a_out} !== 2'b10) begin n_bad++; $display("FAIL read_addr_ack: oe/out got %b%b want 10", a_oe, a_out); end
        read_byte(1'b0, d0);
        rd_data_in = 16'h0000;
        read_byte(1'b1, d1);
        n_cmp++; if (samp_oe !== 1'b0) begin n_bad++; $display("FAIL read_release_in_ack: oe got %b want 0", samp_oe); end
        n_cmp++; if (d0 !== 8'hA5) begin n_bad++; $display("FAIL read_byte0: got %h want a5", d0); end
        n_cmp++; if (d1 !== 8'hC3) begin n_bad++; $display("FAIL read_byte1: got %h want c3", d1); end
        oe_seen = 1'b0;
        bus_stop();
        n_cmp++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL read_oe_after_nack: got %b want 0", oe_seen); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL read_busy_fall: got %b want 0", busy); end
    endtask

    task automatic test_mismatch();
        logic a_oe, a_out;
        oe_seen = 1'b0; wv_count = 0;
        bus_start();
        send_byte(8'h22, a_oe, a_out);
        send_byte(8'h11, a_oe, a_out);
        send_byte(8'h33, a_oe, a_out);
        bus_stop();
        n_cmp++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL mismatch_oe: got %b want 0", oe_seen); end
        n_cmp++; if (wv_count !== 0) begin n_bad++; $display("FAIL mismatch_wr_valid: got %0d want 0", wv_count); end
        i2c_addr = 7'h00;
        bus_start();
        send_byte(8'h00, a_oe, a_out);
        bus_stop();
        n_cmp++; if (oe_seen !== 1'b0) begin n_bad++; $display("FAIL general_call_oe: got %b want 0", oe_seen); end
        i2c_addr = 7'h2A;
    endtask

    task automatic test_early_stop();
        logic a_oe, a_out;
        wv_count = 0;
        bus_start();
        send_byte(8'h54, a_oe, a_out);
        send_byte(8'h12, a_oe, a_out);
        n_cmp++; if ({a_oe, a_out} !== 2'b10) begin n_bad++; $display("FAIL early_data_ack: oe/out got %b%b want 10", a_oe, a_out); end
        bus_stop();
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_bad++; $display("FAIL early_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        n_cmp++; if (wr_data !== 16'hBEEF) begin n_bad++; $display("FAIL early_wr_data: got %h want beef", wr_data); end
        n_cmp++; if (wv_count !== 0) begin n_bad++; $display("FAIL early_wr_valid: got %0d want 0", wv_count); end
    endtask

    task automatic test_repeated_start();
        logic a_oe, a_out;
        logic [7:0] d0;
        rd_data_in = 16'hA5C3;
        bus_start();
        send_byte(8'h55, a_oe, a_out);
        read_byte(1'b0, d0);
        n_cmp++; if (d0 !== 8'hA5) begin n_bad++; $display("FAIL rs_read_byte0: got %h want a5", d0); end
        bus_start();
        n_cmp++; if (sda_oe !== 1'b0) begin n_bad++; $display("FAIL rs_tx_abort_oe: got %b want 0", sda_oe); end
        n_cmp++; if (dut.state_q !== ST_ADDR) begin n_bad++; $display("FAIL rs_state: got %0d want %0d", dut.state_q, ST_ADDR); end
        wv_count = 0;
        send_byte(8'h54, a_oe, a_out);
        n_cmp++; if ({a_oe, a_out} !== 2'b10) begin n_bad++; $display("FAIL rs_addr_ack: oe/out got %b%b want 10", a_oe, a_out); end
        send_byte(8'h0F, a_oe, a_out);
        send_byte(8'h0F, a_oe, a_out);
        bus_stop();
        n_cmp++; if (wr_data !== 16'h0F0F) begin n_bad++; $display("FAIL rs_wr_data: got %h want 0f0f", wr_data); end
        n_cmp++; if (wv_count !== 1) begin n_bad++; $display("FAIL rs_wr_valid: got %0d want 1", wv_count); end
    endtask

    task automatic test_reset_mid_rx();
        logic a_oe, a_out, v;
        logic [7:0] b;
        b = 8'h3C;
        bus_start();
        send_byte(8'h54, a_oe, a_out);
        for (int i = 7; i >= 5; i--) clock_bit(b[i], v);
        scl = 1'b0;
        wclk(2);
        m_sda = b[4];
        wclk(1);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (sda_out !== 1'b1)  begin n_bad++; $display("FAIL midrst_sda_out: got %b want 1", sda_out); end
        n_cmp++; if (sda_oe !== 1'b0)   begin n_bad++; $display("FAIL midrst_sda_oe: got %b want 0", sda_oe); end
        n_cmp++; if (wr_data !== 16'h0) begin n_bad++; $display("FAIL midrst_wr_data: got %h want 0000", wr_data); end
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_wr_valid: got %b want 0", wr_valid); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        wclk(2);
        rst = 1'b0;
        scl = 1'b1;
        m_sda = 1'b1;
        wclk(4);
        test_write(8'h3C, 8'h5A, "post_reset");
    endtask

    initial begin
        test_reset();
        test_write(8'hBE, 8'hEF, "write");
        test_read();
        test_mismatch();
        test_early_stop();
        test_repeated_start();
        test_reset_mid_rx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/i2c_transaction_receiver.md
# i2c_transaction_receiver

- I2C target (responder) paired with the team's I2C transaction generator on the same `clk`.
- Oversamples `scl`/`sda_in` and detects START, STOP and SCL edges.
- Matches a 7-bit address and completes one 16-bit transfer (two bytes, MSB first):
  - master write: captures into `wr_data` with a one-cycle `wr_valid`;
  - master read: shifts out `rd_data_in`.

## Interface
Parameters:
- `DATA_BYTES`, default 2: bytes per transfer; the data shift register is 8*`DATA_BYTES` bits wide.

Ports:
- `clk  in  1`: system clock; SCL is at most `clk`/4.
- `rst  in  1`: reset, asynchronous, active-high.
- `scl  in  1`: I2C clock from master.
- `sda_in  in  1`: resolved SDA line.
- `i2c_addr  in  7`: own target address, sampled at each address compare.
- `rd_data_in  in  16`: word returned on a master read, latched at address ACK.
- `sda_out  out  1`: SDA drive value.
- `sda_oe  out  1`: SDA drive enable; 1 means this block drives.
- `wr_data  out  16`: last complete word written by the master.
- `wr_valid  out  1`: one-cycle pulse when `wr_data` updates.
- `busy  out  1`: high from START detect until STOP or return to IDLE.

## Operation
- Inputs register once into `scl_q`/`sda_q`; previous values are held in `scl_qq`/`sda_qq`.
- Edge events:
  - `scl_rise` = `scl_q & ~scl_qq`; `scl_fall` = `~scl_q & scl_qq`.
  - `start` = `scl_q & scl_qq & sda_qq & ~sda_q`.
  - `stop` = `scl_q & scl_qq & ~sda_qq & sda_q`.
- SDA is sampled only on `scl_rise`; SDA drive changes only on `scl_fall`.
- States:
  - IDLE: `sda_oe`=0; `start` -> ADDR with bit count 7.
  - ADDR: shift 8 bits (7 address + R/W, MSB first) on `scl_rise`. After the 8th bit, at the next `scl_fall`:
    - match -> ADDR_ACK, drive `sda_out`=0, `sda_oe`=1;
    - mismatch -> IGNORE.
  - ADDR_ACK: at the following `scl_fall`:
    - if R/W=1: latch `rd_data_in`, go to TX, drive its MSB;
    - if R/W=0: release and go to RX.
  - RX: shift 8 bits on `scl_rise`; at the next `scl_fall`, go to RX_ACK and drive 0.
  - RX_ACK: at `scl_fall`, release.
    - If more bytes remain -> RX.
    - Otherwise, in the same cycle, `wr_data` <= shift register, `wr_valid`=1, next state IGNORE.
  - TX: present bit n at each `scl_fall`. After the 8th bit's `scl_fall`, release (`sda_oe`=0) -> TX_ACK.
  - TX_ACK: sample master ACK on `scl_rise`.
    - ACK (0) with bytes remaining: at the next `scl_fall` -> TX with the next byte's MSB.
    - NACK, or last byte done -> IGNORE.
  - IGNORE: `sda_oe`=0, wait.
- From any state:
  - `stop` -> IDLE;
  - `start` -> ADDR (repeated START). The transfer is aborted: no `wr_valid`, `wr_data` unchanged.
- Address compare is `{i2c_addr}` == first 7 received bits; the general call (0x00) is not supported and is NACKed.
- Writes beyond `DATA_BYTES` are NACKed in IGNORE, since SDA is released.

## Timing
- Reset values (asynchronous, immediate):
  - outputs: `sda_out`=1, `sda_oe`=0, `wr_data`=0, `wr_valid`=0, `busy`=0;
  - internals: state IDLE, all registers 0, except `scl_q`/`scl_qq`/`sda_q`/`sda_qq`=1 (idle bus).
- Event detection latency is 2 `clk` after the pin change. Drive changes occur the cycle after the detected `scl_fall`, i.e. ≥1 `clk` before the next SCL rise at `clk`/4.
- `wr_valid` asserts for exactly 1 `clk`, in the cycle after the final ACK's `scl_fall`.
- A simultaneous SCL and SDA change in one sample is a data event only: START/STOP require SCL high in both samples.
- `busy` rises the cycle after `start`, falls the cycle after `stop`. It also falls on entry to IDLE via reset.
- `rd_data_in` changes after the ADDR_ACK latch do not affect the ongoing read.

## Structure
- Shared package `i2c_pkg` holds:
  - state encodings, a 4-bit width shared with the generator's encoding style;
  - `I2C_BYTE_BITS`=8;
  - ACK/NACK constants.
- Sub-module `i2c_bus_monitor`: sampling flops plus `scl_rise`/`scl_fall`/`start`/`stop` outputs. It is reusable by the generator for clock-stretch or arbitration work later.
- Top level holds the FSM, bit/byte counters and the shift register.

## Test plan
- Write, `i2c_addr`=0x2A: master sends 0x54, 0xBE, 0xEF.
  - Block drives ACK (`sda_oe`=1, `sda_out`=0) in all three 9th clocks.
  - `wr_data`=0xBEEF, `wr_valid` high 1 cycle.
- Read, `i2c_addr`=0x2A, `rd_data_in`=0xA5C3: master sends 0x55.
  - ACK, then SDA bits 1010_0101, master ACK, then 1100_0011.
  - Master NACK -> `sda_oe`=0 through STOP; `busy` falls.
- Address mismatch: master sends 0x22 (`i2c_addr`=0x2A).
  - `sda_oe` stays 0 for the whole transaction; no `wr_valid`.
- Early STOP after first data byte 0x12:
  - state IDLE, `wr_data` keeps its previous value 0xBEEF, no `wr_valid`.
- Repeated START mid-read, then a write of 0x0F0F:
  - TX aborts; the new address is ACKed; `wr_data`=0x0F0F.
- `rst` pulse during RX bit 4:
  - all outputs at reset values in the same cycle;
  - the next full write transaction completes normally.
